iterative_multiplier: RTL and testbench

Unsigned N-bit shift-and-add multiplier that produces a 2N-bit product over N iteration cycles. It is the inverse-direction companion to the iterative divider: the same start/done handshake and the same enable-controlled register datapath style. Bench use: multiply the divider's quotient by its divisor and add the remainder to check the dividend. Single clock domain; one operation in flight at a time.

---
 rtl/iterative_multiplier.sv | 77 +++++++
 tb/tb_iterative_multiplier.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/iterative_multiplier.sv
// Unsigned N-bit shift-and-add multiplier: start/done handshake, 2N-bit product after N iterations.
module iterative_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, next_state;
  logic [2*N-1:0] mcand, acc, sum;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           last;

  always_comb begin
    last = (cnt == CW'(N - 1));
    sum  = mplier[0] ? acc + mcand : acc;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // P is written only on the final iteration so it holds across later operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{N{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) P <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier (N=4) against a plain-arithmetic product model.
module tb_iterative_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  iterative_multiplier #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A(A), .B(B), .P(P), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one product; latency counted in edges after the accepting edge.
  task automatic run_op(input int a, input int b, input string tag, output int prod);
    int k, lat, busy_cnt;
    bit seen;
    @(negedge clk);
    A = a[N-1:0]; B = b[N-1:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = N'($urandom); B = N'($urandom);
    k = 0; lat = -1; busy_cnt = 0; seen = 1'b0;
    while (k < 20 && !(seen && !busy)) begin
      if (busy) busy_cnt++;
      if (done && !seen) begin seen = 1'b1; lat = k; end
      @(posedge clk); #1;
      k++;
    end
    prod = int'(P);
    check({tag, "_latency"}, lat, N);
    check({tag, "_busy_cycles"}, busy_cnt, N + 1);
    check({tag, "_P"}, prod, a * b);
  endtask

  initial begin
    int prod, k, ndone, last_done, first_done;
    int q, r, d, v;

    // reset with start held high: nothing may start
    reset = 1'b1; start = 1'b1; A = 4'd3; B = 4'd3;
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_P", int'(P), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
    end
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_busy", int'(busy), 0);

    run_op(13, 11, "basic_13x11", prod);
    run_op(15, 15, "max_15x15", prod);
    run_op(0, 9, "zero_a", prod);
    run_op(7, 0, "zero_b", prod);
    run_op(1, 15, "one_x15", prod);

    // start pulses during CALC and DONE are ignored
    @(negedge clk); A = 4'd5; B = 4'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; A = 4'd2; B = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("ign_done", int'(done), 1);
    check("ign_P", int'(P), 30);
    start = 1'b1; A = 4'd2; B = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    check("ign_busy_after_done", int'(busy), 0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ign_extra_dones", ndone, 0);
    check("ign_P_hold", int'(P), 30);

    // start held high: one result per N+2 cycles
    @(negedge clk); A = 4'd3; B = 4'd5; start = 1'b1;
    ndone = 0; last_done = -1; first_done = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("cont_P", int'(P), 15);
        if (first_done < 0) first_done = c;
        else check("cont_interval", c - last_done, N + 2);
        last_done = c;
      end
    end
    check("cont_first_done", first_done, N + 1);
    check("cont_count", ndone, 5);
    @(negedge clk); start = 1'b0;
    k = 0;
    while (busy && k < 20) begin @(posedge clk); #1; k++; end
    check("cont_drain", int'(busy), 0);

    // reset two cycles after acceptance discards the operation
    @(negedge clk); A = 4'd9; B = 4'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("midrst_P", int'(P), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(3, 4, "after_rst_3x4", prod);

    // exhaustive operand sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(a, b, "sweep", prod);

    // random operands
    repeat (20) run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), "rand", prod);

    // recover dividend from quotient*divisor + remainder
    repeat (12) begin
      d = int'($urandom_range(15, 0));
      v = int'($urandom_range(15, 1));
      q = d / v; r = d % v;
      run_op(q, v, "div_qv", prod);
      check("div_dividend", prod + r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
